// File: rtl/tracker_pkg.sv
// tracker_pkg: shared sequencer state enum, note-field codes and note slice helper.
package tracker_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} seq_state_t;
  localparam logic [7:0] NOTE_EMPTY = 8'h00;
  localparam logic [7:0] NOTE_OFF = 8'hFF;
  function automatic logic [7:0] note_field(input logic [15:0] entry);
    return 8'(entry >> 8);
  endfunction
endpackage

// File: rtl/tracker_sequencer_tick_divider.sv
// tick_divider: divides clk into tempo ticks; a period of 0 behaves as 1.
module tick_divider #(
  parameter int TICK_W = 24
) (
  input  logic              clk,
  input  logic              rst_active_low,
  input  logic              clr,
  input  logic              en,
  input  logic [TICK_W-1:0] tick_period,
  output logic              tick_strobe
);
  logic [TICK_W-1:0] cnt_q, cnt_d, last;
  assign last = tick_period == '0 ? '0 : tick_period - 1'b1;
  // >= so a live shrink of the period below the running count still ticks
  assign tick_strobe = en && cnt_q >= last;
  assign cnt_d = clr ? '0 : !en ? cnt_q : tick_strobe ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_active_low)
    if (!rst_active_low) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tracker_sequencer.sv
// tracker_sequencer: tempo-divided row/phrase chain playback issuing per-channel note pulses.
// Defining TRACKER_SEQ_SWING_EN adds swing_ticks, lengthening odd rows.
module tracker_sequencer
  import tracker_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_ROWS = 16,
  parameter int NUM_PHRASES = 16,
  parameter int ENTRY_W = 16,
  parameter int TICK_W = 24,
  localparam int ROW_W = $clog2(NUM_ROWS),
  localparam int PH_W = $clog2(NUM_PHRASES)
) (
  input  logic                            clk,
  input  logic                            rst_active_low,
  input  logic                            play_enable,
  input  logic                            loop_enable,
  input  logic                            restart,
  input  logic [TICK_W-1:0]               tick_period,
  input  logic [4:0]                      ticks_per_row,
  input  logic [PH_W:0]                   chain_len,
`ifdef TRACKER_SEQ_SWING_EN
  input  logic [3:0]                      swing_ticks,
`endif
  input  logic [NUM_CHANNELS*ENTRY_W-1:0] row_data,
  output logic [ROW_W-1:0]                row,
  output logic [PH_W-1:0]                 phrase_idx,
  output logic                            row_strobe,
  output logic                            tick_strobe,
  output logic [NUM_CHANNELS-1:0]         note_on,
  output logic [NUM_CHANNELS-1:0]         note_off,
  output logic [NUM_CHANNELS*ENTRY_W-1:0] entry_out,
  output logic                            playing,
  output logic                            end_of_song
);
`ifdef TRACKER_SEQ_SWING_EN
  localparam int CNT_W = 6;
`else
  localparam int CNT_W = 5;
`endif
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  seq_state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, row_len, swing_add;
  logic [NUM_CHANNELS*ENTRY_W-1:0] entry_q, entry_d;
  logic [PH_W:0] chain_eff;
  logic row_done, at_end;

`ifdef TRACKER_SEQ_SWING_EN
  assign swing_add = row_q[0] ? CNT_W'(swing_ticks) : '0;
`else
  assign swing_add = '0;
`endif
  assign row_len = (ticks_per_row == '0 ? CNT_W'(1) : CNT_W'(ticks_per_row)) + swing_add;
  assign chain_eff = chain_len == '0 ? (PH_W+1)'(1) :
                     chain_len > (PH_W+1)'(NUM_PHRASES) ? (PH_W+1)'(NUM_PHRASES) : chain_len;
  assign row_done = tick_strobe && cnt_q == row_len - 1'b1;
  // >= keeps a live chain_len shrink from running past the new end
  assign at_end = row_q == ROW_LAST && {1'b0, ph_q} >= chain_eff - 1'b1;

  tick_divider #(.TICK_W(TICK_W)) u_div (
    .clk(clk),
    .rst_active_low(rst_active_low),
    .clr(state_q != S_WAIT || restart),
    .en(state_q == S_WAIT),
    .tick_period(tick_period),
    .tick_strobe(tick_strobe)
  );

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [7:0] note;
    assign note = note_field(row_data[c*ENTRY_W +: 16]);
    assign note_on[c] = state_q == S_ISSUE && note != NOTE_EMPTY && note != NOTE_OFF;
    assign note_off[c] = state_q == S_ISSUE && note == NOTE_OFF;
  end

  always_comb begin
    state_d = state_q;
    row_d = row_q;
    ph_d = ph_q;
    entry_d = state_q == S_ISSUE ? row_data : entry_q;
    cnt_d = state_q == S_WAIT && play_enable && !row_done ? cnt_q + CNT_W'(tick_strobe) : '0;
    end_of_song = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = play_enable ? S_FETCH : S_IDLE;
      S_FETCH: state_d = play_enable ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!play_enable) state_d = S_IDLE;
        else if (row_done && at_end) begin
          row_d = '0;
          ph_d = '0;
          state_d = loop_enable ? S_FETCH : S_IDLE;
          end_of_song = !loop_enable;
        end else if (row_done) begin
          row_d = row_q == ROW_LAST ? '0 : row_q + 1'b1;
          ph_d = row_q == ROW_LAST ? ph_q + 1'b1 : ph_q;
          state_d = S_FETCH;
        end
      end
    endcase
    if (restart) begin
      row_d = '0;
      ph_d = '0;
      cnt_d = '0;
      end_of_song = 1'b0;
      state_d = play_enable ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_active_low)
    if (!rst_active_low) begin
      state_q <= S_IDLE;
      row_q <= '0;
      ph_q <= '0;
      cnt_q <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      entry_q <= entry_d;
    end

  assign row = row_q;
  assign phrase_idx = ph_q;
  assign row_strobe = state_q == S_FETCH;
  assign playing = state_q != S_IDLE;
  assign entry_out = entry_q;
endmodule

// File: tb/tb_tracker_sequencer.sv
// tb_tracker_sequencer: directed vectors with hand-computed expectations for tracker_sequencer.
module tb_tracker_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, play = 1'b0, loop_en = 1'b0, restart = 1'b0;
  logic [23:0] tp = 24'd3;
  logic [4:0] tpr = 5'd2;
  logic [4:0] clen = 5'd2;
  logic [63:0] rdata = {16'h0012, 16'hFF34, 16'h0056, 16'h3C12};
  logic [3:0] row, ph, non, noff;
  logic rs, ts, playing, eos;
  logic [63:0] ent;
`ifdef TRACKER_SEQ_SWING_EN
  logic [3:0] swing = 4'd0;
`endif
  int errors = 0, checks = 0, eos_cnt = 0, n, t;

  tracker_sequencer dut (
    .clk(clk),
    .rst_active_low(rst_n),
    .play_enable(play),
    .loop_enable(loop_en),
    .restart(restart),
    .tick_period(tp),
    .ticks_per_row(tpr),
    .chain_len(clen),
`ifdef TRACKER_SEQ_SWING_EN
    .swing_ticks(swing),
`endif
    .row_data(rdata),
    .row(row),
    .phrase_idx(ph),
    .row_strobe(rs),
    .tick_strobe(ts),
    .note_on(non),
    .note_off(noff),
    .entry_out(ent),
    .playing(playing),
    .end_of_song(eos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_strobe(output int cyc, output int ticks);
    cyc = 0;
    ticks = 0;
    do begin
      @(negedge clk);
      cyc++;
      ticks += int'(ts);
      eos_cnt += int'(eos);
    end while (!rs && cyc < 200);
    chk("strobe_seen", rs, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_row", row, 0);
    chk("rst_phrase", ph, 0);
    chk("rst_playing", playing, 0);
    chk("rst_strobe", rs, 0);
    chk("rst_entry", ent, 0);
    chk("rst_notes", {non, noff}, 0);
    chk("rst_eos", eos, 0);
    play = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("fetch_strobe", rs, 1);
    chk("fetch_row", row, 0);
    chk("fetch_playing", playing, 1);
    @(negedge clk);
    chk("issue_on", non, 4'b0001);
    chk("issue_off", noff, 4'b0100);
    chk("issue_strobe", rs, 0);
    @(negedge clk);
    chk("entry_latched", ent, 64'h0012FF3400563C12);
    chk("wait_notes", {non, noff}, 0);
    wait_strobe(n, t);
    chk("first_period", n, 6);
    chk("ticks_in_row", t, 2);
    chk("row_adv", row, 1);
    repeat (4) wait_strobe(n, t);
    chk("row_period", n, 8);
    chk("at_row5", row, 5);
    repeat (2) @(negedge clk);
    play = 1'b0;
    @(negedge clk);
    chk("paused", playing, 0);
    chk("paused_row", row, 5);
    chk("paused_notes", {non, noff}, 0);
    repeat (9) @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    chk("resume_strobe", rs, 1);
    chk("resume_row", row, 5);
    tp = 24'd1;
    tpr = 5'd1;
    eos_cnt = 0;
    repeat (26) wait_strobe(n, t);
    chk("fast_period", n, 3);
    chk("last_row", row, 15);
    chk("last_phrase", ph, 1);
    chk("no_early_eos", eos_cnt, 0);
    repeat (2) @(negedge clk);
    chk("eos_pulse", eos, 1);
    @(negedge clk);
    chk("eos_once", eos, 0);
    chk("end_idle", playing, 0);
    chk("end_row", row, 0);
    chk("end_phrase", ph, 0);
    loop_en = 1'b1;
    eos_cnt = 0;
    @(negedge clk);
    chk("replay_strobe", rs, 1);
    repeat (31) wait_strobe(n, t);
    chk("loop_last_phrase", ph, 1);
    wait_strobe(n, t);
    chk("loop_row", row, 0);
    chk("loop_phrase", ph, 0);
    chk("loop_no_eos", eos_cnt, 0);
    loop_en = 1'b0;
    repeat (31) wait_strobe(n, t);
    repeat (2) @(negedge clk);
    chk("pre_restart_eos", eos, 1);
    restart = 1'b1;
    #1;
    chk("restart_kills_eos", eos, 0);
    @(negedge clk);
    restart = 1'b0;
    chk("restart_fetch", rs, 1);
    chk("restart_row", row, 0);
    chk("restart_phrase", ph, 0);
    chk("restart_no_eos", eos_cnt, 0);
    tp = 24'd0;
    clen = 5'd0;
    wait_strobe(n, t);
    chk("tp0_period", n, 3);
    repeat (14) wait_strobe(n, t);
    chk("clen0_row", row, 15);
    repeat (2) @(negedge clk);
    chk("clen0_eos", eos, 1);
    wait_strobe(n, t);
    wait_strobe(n, t);
    repeat (2) @(negedge clk);
    chk("pre_reset_row", row, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_row", row, 0);
    chk("async_rst_playing", playing, 0);
    chk("async_rst_entry", ent, 0);
`ifdef TRACKER_SEQ_SWING_EN
    tp = 24'd1;
    tpr = 5'd2;
    clen = 5'd2;
    swing = 4'd1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("swing_fetch", rs, 1);
    wait_strobe(n, t);
    chk("swing_even_period", n, 4);
    wait_strobe(n, t);
    chk("swing_odd_period", n, 5);
    wait_strobe(n, t);
    chk("swing_even_again", n, 4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tracker_sequencer.md
# tracker_sequencer

Parametrised multi-channel playback sequencer for the tracker, replacing the fixed four-channel, single-phrase playback path. It divides `clk` into tempo ticks and steps through rows of a chain of phrases. Each row start presents a row/phrase address to the phrase store. One cycle later it captures the returned entries and issues per-channel note-on/note-off pulses to the voice engines. It sits between the phrase store and the synth voices, under `tracker_top`.

## Interface
- `NUM_CHANNELS`, 4, voice channels driven in parallel
- `NUM_ROWS`, 16, rows per phrase; `ROW_W = $clog2(NUM_ROWS)`
- `NUM_PHRASES`, 16, max phrases in a chain; `PH_W = $clog2(NUM_PHRASES)`
- `ENTRY_W`, 16, bits per channel entry
- `TICK_W`, 24, width of the tick period counter

Ports:
- `clk`  in  1  system clock, 100 MHz
- `rst_active_low`  in  1  asynchronous, active-low reset
- `play_enable`  in  1  level; high = play, low = pause
- `loop_enable`  in  1  level; wrap the chain at its end instead of stopping
- `restart`  in  1  one-cycle pulse; return to phrase 0, row 0
- `tick_period`  in  TICK_W  clk cycles per tick; 0 is treated as 1
- `ticks_per_row`  in  5  ticks per row; 0 is treated as 1
- `chain_len`  in  PH_W+1  phrases in the chain; 0 is treated as 1; values above NUM_PHRASES saturate to NUM_PHRASES
- `row_data`  in  NUM_CHANNELS*ENTRY_W  phrase store read data; valid 1 cycle after `row_strobe`
- `row`  out  ROW_W  current row address
- `phrase_idx`  out  PH_W  current phrase address
- `row_strobe`  out  1  one-cycle pulse marking a new row address
- `tick_strobe`  out  1  one-cycle pulse per tick
- `note_on`  out  NUM_CHANNELS  per-channel one-cycle pulse
- `note_off`  out  NUM_CHANNELS  per-channel one-cycle pulse
- `entry_out`  out  NUM_CHANNELS*ENTRY_W  latched entries of the current row
- `playing`  out  1  high in FETCH, ISSUE and WAIT
- `end_of_song`  out  1  one-cycle pulse when a non-looping chain finishes

## Operation
- Entry note field is `entry[15:8]`:
  - 8'h00: empty, no pulse.
  - 8'hFF: `note_off[ch]` pulse.
  - Any other value: `note_on[ch]` pulse.
- FSM states: IDLE, FETCH, ISSUE, WAIT.
- IDLE:
  - All pulses are low and `playing` is 0.
  - `row` and `phrase_idx` hold the paused position.
  - `play_enable` high → FETCH.
- FETCH: assert `row_strobe` for one cycle with the address on `row`/`phrase_idx`; → ISSUE.
- ISSUE:
  - Capture `row_data` into `entry_out`.
  - Pulse `note_on`/`note_off` per channel.
  - Clear the in-row tick count; → WAIT.
- WAIT:
  - The tick divider runs and `tick_strobe` pulses when the divider count equals `tick_period-1`.
  - On the tick where the in-row count equals `ticks_per_row-1`, advance the position and go to FETCH.
  - Advance rule: increment `row`. At `NUM_ROWS-1`, `row` wraps to 0 and `phrase_idx` increments.
  - Chain end: at the last row of phrase `chain_len-1`:
    - If `loop_enable` is set, go to phrase 0, row 0, then FETCH.
    - Otherwise pulse `end_of_song`, reset the position to 0/0, and go to IDLE.
- Pause:
  - If `play_enable` is low in FETCH or WAIT, go to IDLE the next cycle.
  - The position is kept; the tick divider and in-row count are cleared.
  - Resume replays the current row from FETCH.
- `restart`:
  - Sets the position to 0/0 and clears the divider and in-row count.
  - If `play_enable` is high, the next state is FETCH.
  - `restart` wins over a simultaneous advance or `end_of_song`; in that case `end_of_song` is suppressed.
- `tick_period`, `ticks_per_row` and `chain_len` are sampled live. A change takes effect at the next comparison.

## Timing
- Reset values: all outputs 0, `entry_out` all zeros, state IDLE.
- From `play_enable` sampled high, `row_strobe` follows 1 cycle later, and `note_on` and `entry_out` update 2 cycles later.
- Row period = `tick_period * ticks_per_row + 2` cycles (FETCH and ISSUE overhead).
- `row_strobe`, `note_on`/`note_off` and `end_of_song` never last more than 1 cycle.
- Reset asserted mid-row aborts immediately to the reset values.

## Configuration
- `TRACKER_SEQ_SWING_EN` defined:
  - Adds input `swing_ticks` (4 bits).
  - Odd rows last `ticks_per_row + swing_ticks` ticks; even rows last `ticks_per_row`.
  - The in-row counter is widened to 6 bits.
- Undefined: there is no `swing_ticks` port and every row lasts `ticks_per_row` ticks.

## Structure
- `tracker_pkg` holds:
  - `seq_state_t` (the FSM state enum)
  - `NOTE_EMPTY = 8'h00`
  - `NOTE_OFF = 8'hFF`
  - a note-field slice helper
- Sub-module `tick_divider` contains the TICK_W counter, `tick_period` clamping, a synchronous clear, and the `tick_strobe` output.

## Test plan
- Reset release, `play_enable=1`, `tick_period=3`, `ticks_per_row=2` → `row_strobe` at cycle 1, `note_on` at cycle 2, next `row_strobe` 8 cycles later.
- `row_data` with ch0=8'h3C, ch1=8'h00, ch2=8'hFF → `note_on=4'b0001`, `note_off=4'b0100`, `entry_out` latched.
- `chain_len=2`, `loop_enable=0` → after phrase 1 row 15: `end_of_song` pulse, IDLE, position 0/0; with `loop_enable=1` → `phrase_idx` 1→0 with no pulse.
- `play_enable` dropped in WAIT at row 5 and raised 10 cycles later → `row_strobe` again with `row=5`, no skipped row.
- `restart` on the same cycle as the chain-end advance → position 0/0, no `end_of_song`, FETCH next cycle.
- Swing build, `ticks_per_row=2`, `swing_ticks=1`, `tick_period=1` → alternating row periods of 4 and 5 cycles.
